// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder path: operand width derivation and the
// range of operation tags carried alongside each issued pair.
package fp_pkg;

  typedef logic [3:0] fp_id_t;

  localparam fp_id_t ID_FIRST = 4'd1;
  localparam fp_id_t ID_LAST  = 4'd7;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// In-order synchronous FIFO with occupancy count; read data is the current head.
module fp_sync_fifo #(
  parameter  int pWidth = 65,
  parameter  int pDepth = 4,
  localparam int AW     = $clog2(pDepth)
) (
  input  logic              i_Clk,
  input  logic              i_RstN,
  input  logic              i_Push,
  input  logic [pWidth-1:0] iv_Din,
  input  logic              i_Pop,
  output logic [pWidth-1:0] ov_Dout,
  output logic [AW:0]       ov_Level,
  output logic              o_Full,
  output logic              o_Empty
);

  logic [pWidth-1:0] r_Mem [pDepth];
  logic [AW-1:0]     r_Wr;
  logic [AW-1:0]     r_Rd;
  logic [AW:0]       r_Level;
  logic              w_Push;
  logic              w_Pop;

  assign o_Full   = (r_Level == (AW+1)'(pDepth));
  assign o_Empty  = (r_Level == '0);
  assign ov_Level = r_Level;
  assign ov_Dout  = r_Mem[r_Rd];
  assign w_Push   = i_Push && !o_Full;
  assign w_Pop    = i_Pop && !o_Empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_Clk) begin
    if (!i_RstN) begin
      r_Wr    <= '0;
      r_Rd    <= '0;
      r_Level <= '0;
    end else begin
      if (w_Push) r_Wr <= r_Wr + AW'(1);
      if (w_Pop)  r_Rd <= r_Rd + AW'(1);
      case ({w_Push, w_Pop})
        2'b10:   r_Level <= r_Level + (AW+1)'(1);
        2'b01:   r_Level <= r_Level - (AW+1)'(1);
        default: r_Level <= r_Level;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_Push) r_Mem[r_Wr] <= iv_Din;
  end

endmodule

// File: rtl/fp_addsub_feeder.sv
// Queues operand pairs and issues them to the FP add/sub unit under a
// credit limit, tagging each issue with a rolling 1..7 ID.
module fp_addsub_feeder
  import fp_pkg::*;
#(
  parameter  int pWidthExp  = 8,
  parameter  int pWidthMan  = 23,
  parameter  int pFifoDepth = 4,
  parameter  int pCredits   = 8,
  localparam int W          = fp_width(pWidthExp, pWidthMan),
  localparam int LW         = $clog2(pFifoDepth) + 1
) (
  input  logic          i_Clk,
  input  logic          i_RstN,
  input  logic          i_OpValid,
  output logic          o_OpReady,
  input  logic [W-1:0]  iv_OpA,
  input  logic [W-1:0]  iv_OpB,
  input  logic          i_OpSub,
  input  logic          i_CreditRet,
  output logic [W-1:0]  ov_InputA,
  output logic [W-1:0]  ov_InputB,
  output logic          o_SubNotAdd,
  output logic          o_Dv,
  output logic [3:0]    o4_InputID,
  output logic [LW-1:0] ov_Level,
  output logic          o_Full,
  output logic          o_Empty,
  output logic          o_CreditErr
);

  localparam int             FW       = 1 + 2*W;
  localparam int             CW       = $clog2(pCredits + 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(pCredits);

  logic          r_Live;
  logic [CW-1:0] r_Credits;
  fp_id_t        r_NextId;
  logic          w_Push;
  logic          w_Pop;
  logic [FW-1:0] w_FifoDout;

  // r_Live keeps the input closed for the cycle in which reset is applied.
  assign o_OpReady = r_Live && !o_Full;
  assign w_Push    = i_OpValid && o_OpReady;
  assign w_Pop     = !o_Empty && (r_Credits != '0);

  fp_sync_fifo #(
    .pWidth (FW),
    .pDepth (pFifoDepth)
  ) u_fifo (
    .i_Clk    (i_Clk),
    .i_RstN   (i_RstN),
    .i_Push   (w_Push),
    .iv_Din   ({i_OpSub, iv_OpA, iv_OpB}),
    .i_Pop    (w_Pop),
    .ov_Dout  (w_FifoDout),
    .ov_Level (ov_Level),
    .o_Full   (o_Full),
    .o_Empty  (o_Empty)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_RstN) begin
      r_Live      <= 1'b0;
      r_Credits   <= CRED_MAX;
      r_NextId    <= ID_FIRST;
      o_Dv        <= 1'b0;
      o4_InputID  <= '0;
      ov_InputA   <= '0;
      ov_InputB   <= '0;
      o_SubNotAdd <= 1'b0;
      o_CreditErr <= 1'b0;
    end else begin
      r_Live     <= 1'b1;
      o_Dv       <= w_Pop;
      o4_InputID <= w_Pop ? r_NextId : 4'd0;
      if (w_Pop) begin
        {o_SubNotAdd, ov_InputA, ov_InputB} <= w_FifoDout;
        r_NextId <= (r_NextId == ID_LAST) ? ID_FIRST : r_NextId + 4'd1;
      end
      // A return coinciding with an issue cancels out; a surplus return is flagged.
      if (w_Pop && !i_CreditRet) begin
        r_Credits <= r_Credits - CW'(1);
      end else if (!w_Pop && i_CreditRet) begin
        if (r_Credits == CRED_MAX) o_CreditErr <= 1'b1;
        else                       r_Credits   <= r_Credits + CW'(1);
      end
    end
  end

endmodule

// File: doc/fp_addsub_feeder.md
FP_ADDSUB_FEEDER -- requirements
Module: fp_addsub_feeder

Interface
REQ-001 SHALL have parameter pWidthExp, default 8, exponent width.
REQ-002 SHALL have parameter pWidthMan, default 23, mantissa width; W = 1+pWidthExp+pWidthMan.
REQ-003 SHALL have parameter pFifoDepth, default 4, operand FIFO depth, power of two, minimum 2.
REQ-004 SHALL have parameter pCredits, default 8, maximum adder results in flight or buffered downstream.
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 i_Clk  in  1  clock, all logic on rising edge.
REQ-007 i_RstN  in  1  synchronous active-low reset.
REQ-008 i_OpValid  in  1  operand pair offered.
REQ-009 o_OpReady  out  1  FIFO can accept.
REQ-010 iv_OpA, iv_OpB  in  W each  IEEE754 operands.
REQ-011 i_OpSub  in  1  1 = A-B, 0 = A+B.
REQ-012 i_CreditRet  in  1  one-cycle pulse, downstream freed one result slot.
REQ-013 ov_InputA, ov_InputB  out  W each  operands to adder.
REQ-014 o_SubNotAdd  out  1  operation to adder.
REQ-015 o_Dv  out  1  adder input valid.
REQ-016 o4_InputID  out  4  operation tag 1..7, 0 when o_Dv=0.
REQ-017 ov_Level  out  log2(pFifoDepth)+1  FIFO occupancy.
REQ-018 o_Full, o_Empty  out  1 each  FIFO status.
REQ-019 o_CreditErr  out  1  sticky, credit returned while counter at pCredits.

Function
REQ-020 SHALL accept a pair on a rising edge where i_OpValid=1 and o_OpReady=1; o_OpReady = !o_Full, combinational from occupancy.
REQ-021 SHALL store {i_OpSub, iv_OpA, iv_OpB} in an in-order FIFO; no bypass, so an accepted pair is issuable at the following edge at the earliest.
REQ-022 SHALL issue (pop) on an edge where FIFO is non-empty and credit counter > 0; issued data registered onto ov_InputA/ov_InputB/o_SubNotAdd with o_Dv=1 for exactly one cycle per issue.
REQ-023 Minimum latency SHALL be: pair accepted at edge E, o_Dv=1 during the cycle after edge E+1.
REQ-024 At most one issue per cycle; back-to-back issues SHALL be allowed.
REQ-025 Cycles without issue: o_Dv=0, o4_InputID=0, ov_InputA/ov_InputB/o_SubNotAdd hold their last values.
REQ-026 ID counter SHALL start at 1 and increment per issue, wrapping 7->1, never emitting 0.
REQ-027 Credit counter SHALL reset to pCredits: -1 on issue, +1 on i_CreditRet, unchanged when both occur on the same edge.
REQ-028 i_CreditRet with counter = pCredits and no issue that edge SHALL be ignored (counter stays pCredits) and set o_CreditErr until reset.
REQ-029 Push and pop on the same edge SHALL leave ov_Level unchanged; write and read pointers wrap modulo pFifoDepth.
REQ-030 With the FIFO full, i_OpValid SHALL be ignored and the offered pair SHALL not be lost; the source holds it.
REQ-031 Operand contents (NaN, Inf, denormal) SHALL pass through unmodified.

Reset
REQ-032 While i_RstN=0 at an edge: FIFO empty, ov_Level=0, o_Empty=1, o_Full=0, o_OpReady=0, o_Dv=0, o4_InputID=0, ov_InputA=ov_InputB=0, o_SubNotAdd=0, o_CreditErr=0, credits=pCredits, next ID=1.
REQ-033 Reset asserted mid-burst SHALL discard queued pairs; o_OpReady=1 from the first cycle after i_RstN returns high.

Structure
REQ-034 ID range constants (first 1, last 7) and W derivation SHALL go in shared package fp_pkg, used with the adder and its bench.
REQ-035 The FIFO SHALL be one sub-module, fp_sync_fifo, parameterised on width and depth; credit and ID logic in the top.

Verification (pWidthExp=8, pWidthMan=23, pFifoDepth=4, pCredits=8)
REQ-036 Reset, push A=0x3F800000, B=0x40000000, sub=0 at edge E -> o_Dv=1 after E+1, ov_InputA=0x3F800000, ov_InputB=0x40000000, o4_InputID=1.
REQ-037 Stream 12 pairs, no credit returns -> exactly 8 issues, IDs 1..7,1; then one i_CreditRet pulse -> one more issue with ID 2.
REQ-038 Credits exhausted, push 5 pairs -> 4 accepted, ov_Level=4, o_Full=1, o_OpReady=0, 5th held until a credit return frees a slot.
REQ-039 i_CreditRet on the same edge as an issue -> credit count unchanged; the next issue is not blocked.
REQ-040 i_CreditRet after reset with no issues -> o_CreditErr=1 and stays set; credits stay 8; issuing still works.
REQ-041 Assert i_RstN=0 for one edge with 3 pairs queued -> o_Dv=0, ov_Level=0; the next issue carries ID 1.
